// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the 8N1 UART core and its FIFOs.
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;
  localparam int START_MID   = 7;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from pointers carrying an extra wrap bit.
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_doWrite;
  logic          w_doRead;

  // A write into a full FIFO is still legal when a pop frees the slot in the same cycle.
  assign o_empty   = (r_wrPtr == r_rdPtr);
  assign o_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doRead  = i_pop && !o_empty;
  assign w_doWrite = i_push && (!o_full || i_pop);
  assign o_data    = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doWrite) begin
        r_mem[r_wrPtr[AW-1:0]] <= i_data;
        r_wrPtr                <= r_wrPtr + 1'b1;
      end
      if (w_doRead) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: baud tick generator, oversampling receiver and transmitter,
// with a FIFO on each path between the host strobes and the serial pins.
module uart_core
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int FIFO_AW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            rd_uart,
  input  logic [DBIT-1:0] transmit_data,
  input  logic            wr_uart,
  input  logic [15:0]     dvsr,
  input  logic            enable,
  output logic            rx_empty,
  output logic [DBIT-1:0] receive_data,
  output logic            tx_full,
  output logic            tx
);

  localparam int              NW       = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]      OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      MID_TICK = 4'(START_MID);
  localparam logic [3:0]      SB_LAST  = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   BIT_LAST = NW'(DBIT - 1);

  logic [15:0]     r_baudCount;
  logic            w_tick;

  logic [1:0]      r_rxSync;
  logic            w_rxIn;
  rx_state_t       r_rxState;
  logic [3:0]      r_rxTicks;
  logic [NW-1:0]   r_rxBits;
  logic [DBIT-1:0] r_rxShift;
  logic            w_rxDone;
  logic            w_unusedRxFull;

  tx_state_t       r_txState;
  logic [3:0]      r_txTicks;
  logic [NW-1:0]   r_txBits;
  logic [DBIT-1:0] r_txShift;
  logic            r_tx;
  logic            w_txPop;
  logic            w_txEmpty;
  logic [DBIT-1:0] w_txHead;

  // Wrapping on >= keeps the counter bounded if dvsr is lowered mid-count.
  assign w_tick = enable && (r_baudCount >= dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baudCount <= '0;
    end else if (enable) begin
      r_baudCount <= (r_baudCount >= dvsr) ? 16'd0 : r_baudCount + 16'd1;
    end
  end

  assign w_rxIn   = r_rxSync[1];
  assign w_rxDone = (r_rxState == RX_STOP) && w_tick && (r_rxTicks == SB_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxSync  <= 2'b11;
      r_rxState <= RX_IDLE;
      r_rxTicks <= '0;
      r_rxBits  <= '0;
      r_rxShift <= '0;
    end else begin
      r_rxSync <= {r_rxSync[0], rx};
      case (r_rxState)
        RX_IDLE: begin
          if (enable && !w_rxIn) begin
            r_rxState <= RX_START;
            r_rxTicks <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rxTicks == MID_TICK) begin
              r_rxTicks <= '0;
              r_rxBits  <= '0;
              r_rxState <= w_rxIn ? RX_IDLE : RX_DATA;
            end else begin
              r_rxTicks <= r_rxTicks + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rxTicks == OS_LAST) begin
              r_rxTicks <= '0;
              r_rxShift <= {w_rxIn, r_rxShift[DBIT-1:1]};
              if (r_rxBits == BIT_LAST) begin
                r_rxState <= RX_STOP;
              end else begin
                r_rxBits <= r_rxBits + 1'b1;
              end
            end else begin
              r_rxTicks <= r_rxTicks + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rxTicks == SB_LAST) begin
              r_rxState <= RX_IDLE;
            end else begin
              r_rxTicks <= r_rxTicks + 4'd1;
            end
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  // The pin is registered from state, so a frozen FSM also freezes the line level.
  assign w_txPop = (r_txState == TX_IDLE) && enable && !w_txEmpty;
  assign tx      = r_tx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txState <= TX_IDLE;
      r_txTicks <= '0;
      r_txBits  <= '0;
      r_txShift <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_txPop) begin
            r_txShift <= w_txHead;
            r_txTicks <= '0;
            r_txState <= TX_START;
          end
        end
        TX_START: begin
          r_tx <= 1'b0;
          if (w_tick) begin
            if (r_txTicks == OS_LAST) begin
              r_txTicks <= '0;
              r_txBits  <= '0;
              r_txState <= TX_DATA;
            end else begin
              r_txTicks <= r_txTicks + 4'd1;
            end
          end
        end
        TX_DATA: begin
          r_tx <= r_txShift[0];
          if (w_tick) begin
            if (r_txTicks == OS_LAST) begin
              r_txTicks <= '0;
              r_txShift <= r_txShift >> 1;
              if (r_txBits == BIT_LAST) begin
                r_txState <= TX_STOP;
              end else begin
                r_txBits <= r_txBits + 1'b1;
              end
            end else begin
              r_txTicks <= r_txTicks + 4'd1;
            end
          end
        end
        TX_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            if (r_txTicks == SB_LAST) begin
              r_txState <= TX_IDLE;
            end else begin
              r_txTicks <= r_txTicks + 4'd1;
            end
          end
        end
        default: r_txState <= TX_IDLE;
      endcase
    end
  end

  uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rxFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_rxDone),
    .i_pop   (rd_uart),
    .i_data  (r_rxShift),
    .o_data  (receive_data),
    .o_full  (w_unusedRxFull),
    .o_empty (rx_empty)
  );

  uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_txFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (wr_uart),
    .i_pop   (w_txPop),
    .i_data  (transmit_data),
    .o_data  (w_txHead),
    .o_full  (tx_full),
    .o_empty (w_txEmpty)
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: table-driven TX/RX frames, a byte scoreboard,
// and hand-written sequences for glitch, freeze, mid-frame reset and loopback.
module tb_uart_core;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic [7:0] data;
    logic [9:0] expFrame;
  } txVec_t;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic [7:0] expData;
  } rxVec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxDrive = 1'b1;
  logic        loopMode = 1'b0;
  logic        rd_uart = 1'b0;
  logic        wr_uart = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  transmit_data = 8'h00;
  logic [15:0] dvsr = 16'd3;
  logic        rxLine;
  logic        rx_empty;
  logic        tx_full;
  logic        tx;
  logic [7:0]  receive_data;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [7:0]  expQ [$];
  logic [9:0]  txExpQ [$];
  txVec_t      txTable [4];
  rxVec_t      rxTable [4];

  assign rxLine = loopMode ? tx : rxDrive;

  always #5 clk = ~clk;

  uart_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rxLine),
    .rd_uart       (rd_uart),
    .transmit_data (transmit_data),
    .wr_uart       (wr_uart),
    .dvsr          (dvsr),
    .enable        (enable),
    .rx_empty      (rx_empty),
    .receive_data  (receive_data),
    .tx_full       (tx_full),
    .tx            (tx)
  );

  // Hard stop so a wedged DUT can never hang the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic popRx();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    @(negedge clk);
  endtask

  // Drives one 8N1 frame on rx and queues the byte the receiver should store.
  task automatic applyStimulus(input rxVec_t v);
    expQ.push_back(v.expData);
    rxDrive = 1'b0;
    waitClks(BIT_CLKS);
    for (int b = 0; b < 8; b++) begin
      rxDrive = v.data[b];
      waitClks(BIT_CLKS);
    end
    rxDrive = v.stopBit;
    waitClks(20);
    checkOutput("rxEmptyBeforeStopEnd", 16'(rx_empty), 16'd1);
    waitClks(v.stopBit ? 44 : 28);
    rxDrive = 1'b1;
    waitClks(100);
  endtask

  // Waits (bounded) for a received byte, compares it with the scoreboard head, then pops it.
  task automatic checkRxByte(input string name);
    int         n;
    logic [7:0] exp;
    n = 0;
    while (rx_empty && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: scoreboard empty, expected a queued byte", name);
      return;
    end
    exp = expQ.pop_front();
    if (n >= 1000) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: rx_empty stayed 1 for 1000 clocks, expected byte 0x%0h", name, exp);
      return;
    end
    checkOutput(name, 16'(receive_data), 16'(exp));
    popRx();
  endtask

  // Samples one TX frame at bit centres; optionally freezes the baud generator after bit freezeBit.
  task automatic captureTxFrame(input logic [9:0] expFrame, input int freezeBit, output logic [9:0] frame);
    int n;
    int changes;
    n = 0;
    frame = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL txStartTimeout: tx stayed 1 for 400 clocks, expected a start bit");
      return;
    end
    waitClks(BIT_CLKS / 2);
    for (int i = 0; i < 10; i++) begin
      frame[i] = tx;
      if (i == freezeBit) begin
        enable = 1'b0;
        changes = 0;
        repeat (250) begin
          @(negedge clk);
          if (tx !== expFrame[i]) changes++;
        end
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        repeat (249) begin
          @(negedge clk);
          if (tx !== expFrame[i]) changes++;
        end
        checkOutput("freezeTxStable", 16'(changes), 16'd0);
        checkOutput("rdWhileEmpty", 16'(rx_empty), 16'd1);
        enable = 1'b1;
      end
      if (i < 9) waitClks(BIT_CLKS);
    end
  endtask

  initial begin
    logic [9:0] frame;
    logic [9:0] expF;

    txTable[0] = '{data: 8'hA5, expFrame: 10'h34A};
    txTable[1] = '{data: 8'h00, expFrame: 10'h200};
    txTable[2] = '{data: 8'hFF, expFrame: 10'h3FE};
    txTable[3] = '{data: 8'h3C, expFrame: 10'h278};

    rxTable[0] = '{data: 8'h3C, stopBit: 1'b1, expData: 8'h3C};
    rxTable[1] = '{data: 8'h81, stopBit: 1'b1, expData: 8'h81};
    rxTable[2] = '{data: 8'h5A, stopBit: 1'b0, expData: 8'h5A};
    rxTable[3] = '{data: 8'hFF, stopBit: 1'b1, expData: 8'hFF};

    // Reset values while reset_n is held low.
    waitClks(3);
    checkOutput("resetTx", 16'(tx), 16'd1);
    checkOutput("resetRxEmpty", 16'(rx_empty), 16'd1);
    checkOutput("resetTxFull", 16'(tx_full), 16'd0);
    checkOutput("resetRxData", 16'(receive_data), 16'h00);
    reset_n = 1'b1;
    enable  = 1'b1;
    dvsr    = 16'd3;
    waitClks(10);
    checkOutput("postResetTx", 16'(tx), 16'd1);

    // TX table written back-to-back, then each frame captured in order.
    for (int i = 0; i < 4; i++) begin
      transmit_data = txTable[i].data;
      wr_uart = 1'b1;
      txExpQ.push_back(txTable[i].expFrame);
      @(negedge clk);
    end
    wr_uart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expF = txExpQ.pop_front();
      captureTxFrame(expF, -1, frame);
      checkOutput("txFrame", 16'(frame), 16'(expF));
    end
    waitClks(100);

    // RX table, each byte checked at the FIFO head then popped.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rxTable[i]);
      checkRxByte("rxByte");
      checkOutput("rxEmptyAfterPop", 16'(rx_empty), 16'd1);
    end

    // Short low pulse must be rejected at the start-bit midpoint.
    rxDrive = 1'b0;
    waitClks(12);
    rxDrive = 1'b1;
    waitClks(200);
    checkOutput("glitchRejected", 16'(rx_empty), 16'd1);

    // Freeze the baud generator in the middle of a TX frame.
    transmit_data = 8'h96;
    wr_uart = 1'b1;
    txExpQ.push_back(10'h32C);
    @(negedge clk);
    wr_uart = 1'b0;
    expF = txExpQ.pop_front();
    captureTxFrame(expF, 3, frame);
    checkOutput("freezeTxFrame", 16'(frame), 16'(expF));
    waitClks(100);

    // Reset in the middle of an incoming frame leaves nothing behind.
    rxDrive = 1'b0;
    waitClks(BIT_CLKS);
    rxDrive = 1'b1;
    waitClks(BIT_CLKS);
    reset_n = 1'b0;
    waitClks(2);
    checkOutput("midResetRxEmpty", 16'(rx_empty), 16'd1);
    checkOutput("midResetRxData", 16'(receive_data), 16'h00);
    checkOutput("midResetTx", 16'(tx), 16'd1);
    reset_n = 1'b1;
    waitClks(800);
    checkOutput("midResetNoByte", 16'(rx_empty), 16'd1);

    // Loopback: one byte is popped by the transmitter, so the 17th write fills the FIFO
    // and the 18th is dropped.
    loopMode = 1'b1;
    waitClks(5);
    for (int i = 1; i <= 18; i++) begin
      if (i == 17) checkOutput("txFullAfter16", 16'(tx_full), 16'd0);
      if (i == 18) checkOutput("txFullAfter17", 16'(tx_full), 16'd1);
      transmit_data = 8'(i);
      wr_uart = 1'b1;
      if (i <= 17) expQ.push_back(8'(i));
      @(negedge clk);
    end
    wr_uart = 1'b0;
    checkOutput("txFullAfter18", 16'(tx_full), 16'd1);
    for (int i = 0; i < 17; i++) begin
      checkRxByte("loopByte");
    end
    waitClks(1000);
    checkOutput("loopDroppedByte", 16'(rx_empty), 16'd1);
    checkOutput("loopTxDrained", 16'(tx_full), 16'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
